// File: rtl/prefetch_fetcher_if.sv
// Program-memory read bus for prefetch_fetcher.
// master: is_read_valid/read_address out; slave: is_read_ready/read_data out.
interface prefetch_fetcher_if #(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = 16
) ();
  logic                 is_read_valid;
  logic [ADDR_BITS-1:0] read_address;
  logic                 is_read_ready;
  logic [DATA_BITS-1:0] read_data;

  modport master (
    output is_read_valid,
    output read_address,
    input  is_read_ready,
    input  read_data
  );

  modport slave (
    input  is_read_valid,
    input  read_address,
    output is_read_ready,
    output read_data
  );
endinterface

// File: rtl/prefetch_fetcher.sv
// Instruction fetcher with a sequential prefetch FIFO; sequential FETCH hits in 1 cycle.
// Ports: clk, reset (sync, high), core_state, current_pc, prefetch_enable,
// mem (read bus, master), fetcher_state, instruction, buffer_count.
// Define FETCHER_PERF_CNT_EN to add saturating hit_count/miss_count outputs.
module prefetch_fetcher #(
  parameter int PROGRAM_MEM_ADDR_BITS = 8,
  parameter int PROGRAM_MEM_DATA_BITS = 16,
  parameter int PREFETCH_DEPTH        = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [2:0]                       core_state,
  input  logic [PROGRAM_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                             prefetch_enable,
  prefetch_fetcher_if.master               mem,
  output logic [2:0]                       fetcher_state,
  output logic [PROGRAM_MEM_DATA_BITS-1:0] instruction,
  output logic [$clog2(PREFETCH_DEPTH):0]  buffer_count
`ifdef FETCHER_PERF_CNT_EN
  ,
  output logic [15:0]                      hit_count,
  output logic [15:0]                      miss_count
`endif
);

  localparam int AB = PROGRAM_MEM_ADDR_BITS;
  localparam int DB = PROGRAM_MEM_DATA_BITS;
  localparam int PW = $clog2(PREFETCH_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] CORE_FETCH  = 3'b001;
  localparam logic [2:0] CORE_DECODE = 3'b010;

  typedef enum logic [2:0] {
    S_IDLE     = 3'b000,
    S_FETCHING = 3'b001,
    S_FETCHED  = 3'b010
  } state_t;

  state_t state;

  logic [AB-1:0] fifo_addr [PREFETCH_DEPTH];
  logic [DB-1:0] fifo_data [PREFETCH_DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  // rd_demand tags the outstanding read; discard drops a stale prefetch.
  logic          rd_demand;
  logic          discard;
  logic          need_demand;
  logic [AB-1:0] dem_addr;
  logic [AB-1:0] pf_addr;
  logic          pf_stop;

  logic resp;
  logic fetch_req;
  logic hit;
  logic pf_push;
  logic pf_issue;

  assign fetcher_state = state;

  assign resp      = mem.is_read_valid & mem.is_read_ready;
  assign fetch_req = (state == S_IDLE) && (core_state == CORE_FETCH);
  assign hit       = fetch_req && (buffer_count != '0)
                     && (fifo_addr[head] == current_pc);
  assign pf_push   = resp && !rd_demand && !discard;
  assign pf_issue  = (state != S_FETCHING) && !mem.is_read_valid
                     && prefetch_enable && !pf_stop
                     && (buffer_count < CW'(PREFETCH_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= S_IDLE;
      mem.is_read_valid <= 1'b0;
      mem.read_address  <= '0;
      instruction       <= '0;
      buffer_count      <= '0;
      head              <= '0;
      tail              <= '0;
      rd_demand         <= 1'b0;
      discard           <= 1'b0;
      need_demand       <= 1'b0;
      dem_addr          <= '0;
      pf_addr           <= '0;
      pf_stop           <= 1'b0;
`ifdef FETCHER_PERF_CNT_EN
      hit_count         <= '0;
      miss_count        <= '0;
`endif
    end else begin
      if (resp) begin
        mem.is_read_valid <= 1'b0;
        discard           <= 1'b0;
      end

      if (resp && rd_demand) begin
        instruction <= mem.read_data;
        pf_addr     <= mem.read_address + 1'b1;
        pf_stop     <= &mem.read_address;
        state       <= S_FETCHED;
      end

      if (pf_push) begin
        fifo_addr[tail] <= mem.read_address;
        fifo_data[tail] <= mem.read_data;
        tail            <= tail + 1'b1;
        pf_addr         <= pf_addr + 1'b1;
        pf_stop         <= &pf_addr;
      end

      if (hit) begin
        head <= head + 1'b1;
      end

      buffer_count <= buffer_count + CW'(pf_push) - CW'(hit);

      if (pf_issue) begin
        mem.is_read_valid <= 1'b1;
        mem.read_address  <= pf_addr;
        rd_demand         <= 1'b0;
      end

      // Demand deferred behind a discarded prefetch.
      if ((state == S_FETCHING) && need_demand
          && !mem.is_read_valid) begin
        mem.is_read_valid <= 1'b1;
        mem.read_address  <= dem_addr;
        rd_demand         <= 1'b1;
        need_demand       <= 1'b0;
      end

      unique case (state)
        S_IDLE: begin
          if (fetch_req) begin
            if (hit) begin
              instruction <= fifo_data[head];
              state       <= S_FETCHED;
`ifdef FETCHER_PERF_CNT_EN
              if (hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
`endif
            end else begin
              head         <= '0;
              tail         <= '0;
              buffer_count <= '0;
              dem_addr     <= current_pc;
              state        <= S_FETCHING;
              if (mem.is_read_valid && !resp
                  && (mem.read_address == current_pc)) begin
                rd_demand <= 1'b1;
              end else if (mem.is_read_valid) begin
                // A response landing this cycle is dropped as well.
                discard     <= !resp;
                need_demand <= 1'b1;
              end else begin
                mem.is_read_valid <= 1'b1;
                mem.read_address  <= current_pc;
                rd_demand         <= 1'b1;
              end
`ifdef FETCHER_PERF_CNT_EN
              if (miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
`endif
            end
          end
        end
        S_FETCHING: begin
        end
        S_FETCHED: begin
          if (core_state == CORE_DECODE) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
